mem_stage_queue: RTL
====================

// Module: mem_stage_queue
// PURPOSE
//   Parametrised successor of the single-slot MEM stage: a DEPTH-entry in-order queue between PREMEM and WB.
//   Lets several issued loads/stores wait for data_ok at once; ALU/CP0 results pass through in order.
//   Captures returned read data per entry. On flush, discards every queued entry and drops late responses.
// PARAMETERS
//   PAYLOAD_W  96  opaque per-instruction payload bits (writeNum, finalRes, loadSel, alignCheck, ...)
//   DATA_W     32  width of data_rdata_i / out_rdata_o
//   DEPTH      4   queue entries, power of 2, >=2
//   CNT_W      $clog2(DEPTH+1)  width of count_o and the internal drop counter
// PORTS
//   clk          in   1          clock, all state on posedge
//   rst          in   1          synchronous reset, active-high
//   flush_i      in   1          exception flush from CP0 (excOccur)
//   in_valid_i   in   1          PREMEM has an instruction
//   in_memReq_i  in   1          instruction issued a data request (expects exactly one data_ok)
//   in_risk_i    in   1          instruction may still raise an exception
//   in_payload_i in   PAYLOAD_W  instruction payload
//   in_allowin_o out  1          queue accepts this cycle
//   data_ok_i    in   1          one data response, in issue order
//   data_rdata_i in   DATA_W     response data, valid with data_ok_i
//   out_valid_o  out  1          head entry complete, offered to WB
//   out_allowin_i in  1          WB accepts
//   out_payload_o out PAYLOAD_W  head payload
//   out_rdata_o  out  DATA_W     head captured read data (0 if no memReq)
//   count_o      out  CNT_W      occupied entries
//   hasRisk_o    out  1          OR of risk bits over valid entries
//   protoErr_o   out  1          sticky: data_ok with nothing outstanding
// BEHAVIOUR
//   State: circular buffer with head/tail ptrs and count; per entry {valid, memReq, done, risk, payload, rdata};
//     drop_cnt[CNT_W].
//   Reset: all entries invalid; ptrs, count, drop_cnt = 0; protoErr_o = 0.
//     Outputs: in_allowin_o = 1, out_valid_o = 0, count_o = 0, hasRisk_o = 0.
//     out_payload_o / out_rdata_o = 0.
//   Enqueue (enq = in_valid_i & in_allowin_o & !flush_i):
//     entry[tail] <= {1, memReq, 0, risk, payload, 0}; tail++ (wraps modulo DEPTH).
//   in_allowin_o = (count < DEPTH) & (drop_cnt == 0). It is registered-state only, with no path from out_allowin_i.
//     A full queue therefore accepts nothing in the same cycle the head leaves.
//   Head complete = valid & (!memReq | done). out_valid_o = count != 0 & head complete & !flush_i.
//   Dequeue (deq = out_valid_o & out_allowin_i): invalidate head; head++.
//     count updates by enq - deq; simultaneous enq and deq leaves count unchanged.
//   Response routing, priority order:
//     (1) drop_cnt > 0: consume the response, drop_cnt--.
//     (2) otherwise: set done and capture rdata on the oldest valid entry (search from head) with memReq & !done.
//     (3) no such entry: ignore the response, set protoErr_o.
//   data_ok_i never arrives in the same cycle as the enqueue of its own entry (earliest is the next cycle).
//     A response may complete the head entry and let it dequeue in the same cycle.
//     In that case out_rdata_o = data_rdata_i (bypass), and out_valid_o may rise combinationally from data_ok_i.
//   Flush (flush_i = 1):
//     All entries invalid; head = tail = 0; count = 0; enq and deq suppressed.
//     drop_cnt <= drop_cnt + P - (data_ok_i ? 1 : 0).
//       P = number of valid entries with memReq & !done before the flush.
//       A response arriving in the flush cycle is counted against the flushed set.
//     drop_cnt never exceeds DEPTH, because enqueue is blocked while drop_cnt != 0.
//   rst has priority over flush_i. Reset mid-operation discards everything, including drop_cnt.
//     After reset the memory side must be quiescent.
//   hasRisk_o = OR(valid & risk) over entries, combinational from state; it is not gated by flush.
// TESTING
//   1. Reset, then enqueue 1 non-mem entry, out_allowin_i = 1:
//      out_valid_o = 1 on the next cycle with that payload; count 1 -> 0.
//   2. Enqueue 4 memReq entries back-to-back (DEPTH = 4):
//      in_allowin_o = 0 at count 4.
//      data_ok with rdata 0xA1..0xA4 over 4 cycles -> WB receives them in order with matching rdata.
//   3. Head is non-mem and blocked (out_allowin_i = 0); entry 2 is memReq and gets data_ok 0x55:
//      entry 2 done. When WB opens, two consecutive outputs follow, the second with rdata 0x55.
//   4. 3 memReq entries pending, flush with data_ok in the same cycle:
//      count = 0, drop_cnt = 2, in_allowin_o = 0.
//      The next 2 data_ok are dropped; then in_allowin_o = 1 and a new load completes normally.
//   5. data_ok with an empty queue and drop_cnt = 0:
//      protoErr_o rises and stays 1 until rst; queue state unchanged.
//   6. Simultaneous enq and deq at count 2 -> count stays 2.
//      Risk entry present -> hasRisk_o = 1; it falls the cycle after that entry dequeues.

Source files
------------

// File: rtl/mem_stage_queue.sv
// In-order DEPTH-entry queue between PREMEM and WB. Holds issued loads/stores
// until their data_ok arrives, passes non-memory results through in order, and
// drops responses that belong to entries discarded by a flush.
module mem_stage_queue #(
  parameter int PAYLOAD_W = 96,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  input  logic                 in_memReq_i,
  input  logic                 in_risk_i,
  input  logic [PAYLOAD_W-1:0] in_payload_i,
  output logic                 in_allowin_o,
  input  logic                 data_ok_i,
  input  logic [DATA_W-1:0]    data_rdata_i,
  output logic                 out_valid_o,
  input  logic                 out_allowin_i,
  output logic [PAYLOAD_W-1:0] out_payload_o,
  output logic [DATA_W-1:0]    out_rdata_o,
  output logic [CNT_W-1:0]     count_o,
  output logic                 hasRisk_o,
  output logic                 protoErr_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]     valid_q, valid_d;
  logic [DEPTH-1:0]     memreq_q, memreq_d;
  logic [DEPTH-1:0]     done_q, done_d;
  logic [DEPTH-1:0]     risk_q, risk_d;
  logic [PAYLOAD_W-1:0] payload_q [DEPTH];
  logic [PAYLOAD_W-1:0] payload_d [DEPTH];
  logic [DATA_W-1:0]    rdata_q [DEPTH];
  logic [DATA_W-1:0]    rdata_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     drop_q, drop_d;
  logic                 proto_err_q, proto_err_d;

  logic                 resp_hit;
  logic [PTR_W-1:0]     resp_idx;
  logic [PTR_W-1:0]     scan_idx;
  logic [CNT_W-1:0]     pend_cnt;
  logic                 resp_take;
  logic                 head_bypass;
  logic                 head_complete;
  logic                 enq;
  logic                 deq;

  // Locate the oldest outstanding memory entry and count all outstanding ones.
  always_comb begin
    resp_hit = 1'b0;
    resp_idx = head_q;
    scan_idx = head_q;
    pend_cnt = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (valid_q[scan_idx] && memreq_q[scan_idx] && !done_q[scan_idx] && !resp_hit) begin
        resp_hit = 1'b1;
        resp_idx = scan_idx;
      end
      if (valid_q[i] && memreq_q[i] && !done_q[i]) begin
        pend_cnt = pend_cnt + CNT_W'(1);
      end
    end
  end

  // Handshakes and head output, including same-cycle bypass of returning data.
  always_comb begin
    in_allowin_o  = (count_q < CNT_W'(DEPTH)) && (drop_q == '0);
    resp_take     = data_ok_i && (drop_q == '0) && resp_hit;
    head_bypass   = resp_take && (resp_idx == head_q);
    head_complete = valid_q[head_q] && (!memreq_q[head_q] || done_q[head_q] || head_bypass);
    out_valid_o   = (count_q != '0) && head_complete && !flush_i;
    enq           = in_valid_i && in_allowin_o && !flush_i;
    deq           = out_valid_o && out_allowin_i;
    out_payload_o = payload_q[head_q];
    out_rdata_o   = head_bypass ? data_rdata_i : rdata_q[head_q];
    count_o       = count_q;
    hasRisk_o     = |(valid_q & risk_q);
    protoErr_o    = proto_err_q;
  end

  // Next-state: flush, response routing, dequeue, enqueue.
  always_comb begin
    valid_d     = valid_q;
    memreq_d    = memreq_q;
    done_d      = done_q;
    risk_d      = risk_q;
    payload_d   = payload_q;
    rdata_d     = rdata_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    drop_d      = drop_q;
    proto_err_d = proto_err_q;

    if (flush_i) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      // A response in the flush cycle belongs to the flushed set; with nothing
      // outstanding at all it is a protocol error instead.
      if (data_ok_i && (drop_q == '0) && !resp_hit) begin
        proto_err_d = 1'b1;
        drop_d      = pend_cnt;
      end else if (data_ok_i) begin
        drop_d = drop_q + pend_cnt - CNT_W'(1);
      end else begin
        drop_d = drop_q + pend_cnt;
      end
    end else begin
      if (data_ok_i) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CNT_W'(1);
        end else if (resp_hit) begin
          done_d[resp_idx]  = 1'b1;
          rdata_d[resp_idx] = data_rdata_i;
        end else begin
          proto_err_d = 1'b1;
        end
      end
      if (deq) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + PTR_W'(1);
      end
      if (enq) begin
        valid_d[tail_q]   = 1'b1;
        memreq_d[tail_q]  = in_memReq_i;
        done_d[tail_q]    = 1'b0;
        risk_d[tail_q]    = in_risk_i;
        payload_d[tail_q] = in_payload_i;
        rdata_d[tail_q]   = '0;
        tail_d            = tail_q + PTR_W'(1);
      end
      if (enq && !deq) begin
        count_d = count_q + CNT_W'(1);
      end else if (deq && !enq) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      memreq_q    <= '0;
      done_q      <= '0;
      risk_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      drop_q      <= '0;
      proto_err_q <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        payload_q[i] <= '0;
        rdata_q[i]   <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      memreq_q    <= memreq_d;
      done_q      <= done_d;
      risk_q      <= risk_d;
      payload_q   <= payload_d;
      rdata_q     <= rdata_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
